// File: rtl/conbus_arb_rr.sv
// conbus_arb_rr: round-robin sticky/parking bus arbiter for NREQ conbus masters.
// Optional contested hold-time limit is enabled by defining CONBUS_ARB_HOLD_LIMIT_EN.
module conbus_arb_rr #(
    parameter  int NREQ     = 4,
    parameter  int MAX_HOLD = 16,
    localparam int GNT_W    = $clog2(NREQ)
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic [NREQ-1:0]  req,
    output logic [GNT_W-1:0] gnt,
    output logic [NREQ-1:0]  gnt_onehot,
    output logic             rearb
);
    if (NREQ < 2 || NREQ > 16 || MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_params
        $error("conbus_arb_rr: NREQ must be 2..16 and MAX_HOLD 2..255");
    end

    logic [GNT_W-1:0] r_gnt;
    logic [NREQ-1:0]  r_onehot;
    logic             r_rearb;
    logic [GNT_W-1:0] w_cand;
    logic [GNT_W:0]   w_sum;
    logic [GNT_W-1:0] w_next;
    logic             w_own;
    logic             w_others;
    logic             w_hold_trig;
    logic             w_change;

    // Downward scan so the last hit is the nearest requester after the owner.
    always_comb begin
        w_cand = r_gnt;
        w_sum  = '0;
        for (int k = NREQ - 1; k >= 1; k--) begin
            w_sum = {1'b0, r_gnt} + (GNT_W+1)'(k);
            if (w_sum >= (GNT_W+1)'(NREQ)) w_sum = w_sum - (GNT_W+1)'(NREQ);
            if (req[w_sum[GNT_W-1:0]]) w_cand = w_sum[GNT_W-1:0];
        end
    end

    assign w_own    = |(req & r_onehot);
    assign w_others = |(req & ~r_onehot);
    assign w_change = w_others && (!w_own || w_hold_trig);
    assign w_next   = w_change ? w_cand : r_gnt;

`ifdef CONBUS_ARB_HOLD_LIMIT_EN
    logic [7:0] r_hold;

    assign w_hold_trig = w_own && w_others && (r_hold == 8'(MAX_HOLD - 1));

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) r_hold <= '0;
        else            r_hold <= (w_change || !w_others) ? 8'd0 : r_hold + 8'd1;
    end
`else
    assign w_hold_trig = 1'b0;
`endif

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_gnt    <= '0;
            r_onehot <= NREQ'(1);
            r_rearb  <= 1'b0;
        end else begin
            r_gnt    <= w_next;
            r_onehot <= NREQ'(1) << w_next;
            r_rearb  <= w_change;
        end
    end

    assign gnt        = r_gnt;
    assign gnt_onehot = r_onehot;
    assign rearb      = r_rearb;
endmodule

// File: tb/tb_conbus_arb_rr.sv
// tb_conbus_arb_rr: directed vectors for conbus_arb_rr (NREQ=4, MAX_HOLD=4) with a queue scoreboard.
// Expected values follow CONBUS_ARB_HOLD_LIMIT_EN when it is defined.
module tb_conbus_arb_rr;
    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [1:0] gnt;
    logic [3:0] gnt_onehot;
    logic       rearb;

    typedef struct packed {
        logic [1:0] g;
        logic       r;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    bit   done = 1'b0;

    conbus_arb_rr #(.NREQ(4), .MAX_HOLD(4)) dut (
        .sys_clk(sys_clk),
        .sys_rst_n(sys_rst_n),
        .req(req),
        .gnt(gnt),
        .gnt_onehot(gnt_onehot),
        .rearb(rearb)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic step(input logic rst_n, input logic [3:0] r, input logic [1:0] eg, input logic er);
        @(negedge sys_clk);
        sys_rst_n = rst_n;
        req = r;
        q.push_back('{g: eg, r: er});
    endtask

    task automatic check(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            failures++;
            $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, act, exp_v);
        end
    endtask

    initial begin : monitor
        exp_t e;
        logic [3:0] oh;
        forever begin
            @(posedge sys_clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                oh = 4'b0001 << e.g;
                check("gnt", int'(gnt), int'(e.g));
                check("gnt_onehot", int'(gnt_onehot), int'(oh));
                check("rearb", int'(rearb), int'(e.r));
            end
        end
    end

    initial begin : driver
        // reset with all masters requesting
        step(0, 4'b1111, 2'd0, 0);
        step(0, 4'b1111, 2'd0, 0);
        step(1, 4'b1111, 2'd0, 0);
        // walk owner to 2, then release to 3 and wrap 3->0
        step(1, 4'b1110, 2'd1, 1);
        step(1, 4'b1100, 2'd2, 1);
        step(1, 4'b1111, 2'd2, 0);
        step(1, 4'b1011, 2'd3, 1);
        step(1, 4'b0011, 2'd0, 1);
        // parking on owner 1
        step(1, 4'b0010, 2'd1, 1);
        for (int i = 0; i < 10; i++) step(1, 4'b0000, 2'd1, 0);
        step(1, 4'b0100, 2'd2, 1);
        // simultaneous release/assert: search order from o+1
        step(1, 4'b0001, 2'd0, 1);
        step(1, 4'b0001, 2'd0, 0);
        step(1, 4'b1100, 2'd2, 1);
        step(1, 4'b1100, 2'd2, 0);
        step(1, 4'b1000, 2'd3, 1);
        // contested hold with req=0011
        step(1, 4'b0001, 2'd0, 1);
`ifdef CONBUS_ARB_HOLD_LIMIT_EN
        for (int i = 0; i < 3; i++) step(1, 4'b0011, 2'd0, 0);
        step(1, 4'b0011, 2'd1, 1);
        for (int i = 0; i < 3; i++) step(1, 4'b0011, 2'd1, 0);
        step(1, 4'b0011, 2'd0, 1);
        for (int i = 0; i < 2; i++) step(1, 4'b0011, 2'd0, 0);
`else
        for (int i = 0; i < 10; i++) step(1, 4'b0011, 2'd0, 0);
`endif
        // owner 3 with counter at 2, then reset mid-operation
        step(1, 4'b1000, 2'd3, 1);
        step(1, 4'b1001, 2'd3, 0);
        step(1, 4'b1001, 2'd3, 0);
        step(0, 4'b1001, 2'd0, 0);
`ifdef CONBUS_ARB_HOLD_LIMIT_EN
        for (int i = 0; i < 3; i++) step(1, 4'b1001, 2'd0, 0);
        step(1, 4'b1001, 2'd3, 1);
        for (int i = 0; i < 2; i++) step(1, 4'b1001, 2'd3, 0);
`else
        for (int i = 0; i < 6; i++) step(1, 4'b1001, 2'd0, 0);
`endif
        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge sys_clk);
        repeat (2) @(posedge sys_clk);
        check("scoreboard_drained", q.size(), 0);
        done = 1'b1;
    end

    initial begin : finisher
        fork
            wait (done);
            #100000;
        join_any
        if (!done) begin
            failures++;
            $display("FAIL timeout t=%0t got=running expected=done", $time);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
